operand_skid_reg: RTL

- Registered operand stage directly downstream of the 16-bit two-input operand selector in the accumulator datapath.
- Captures the selected operand, plus a tag naming which selector input produced it, and presents it to the ALU/accumulator with a valid/ready handshake.
- A 2-entry skid buffer absorbs ALU back-pressure without combinational ready paths.
- Generates zero and negative flags on the held operand.

---
 rtl/operand_skid_reg_pkg.sv | 29 ++
 rtl/operand_flags.sv | 13 +
 rtl/operand_skid_reg_checker.sv | 21 ++
 rtl/operand_skid_reg.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/operand_skid_reg_pkg.sv
// Shared datapath definitions for the operand stage: word/tag widths,
// selector source encodings and the skid-buffer state encoding.
package operand_skid_reg_pkg;

  localparam int WORD_W = 16;
  localparam int SRC_W  = 1;

  localparam logic [SRC_W-1:0] SRC_A = 1'b0;
  localparam logic [SRC_W-1:0] SRC_B = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Occupancy implied by a buffer state; the unused encoding maps to empty.
  function automatic logic [1:0] state_count(input state_e s);
    logic [1:0] cnt;
    case (s)
      EMPTY:   cnt = 2'd0;
      ONE:     cnt = 2'd1;
      FULL:    cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/operand_flags.sv
// Zero / negative detection on a datapath word; shared with the accumulator stage.
module operand_flags #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             neg
);

  assign zero = (data == {WIDTH{1'b0}});
  assign neg  = data[WIDTH-1];

endmodule

// File: rtl/operand_skid_reg_checker.sv
// Structural invariants of the operand skid buffer, kept out of the datapath.
module operand_skid_reg_checker (
  input logic       clk,
  input logic       rst_n,
  input logic       out_valid,
  input logic       skid_valid,
  input logic       in_ready,
  input logic [1:0] count
);

  count_matches_occupancy: assert property (
    @(posedge clk) disable iff (!rst_n)
    count == ({1'b0, out_valid} + {1'b0, skid_valid})
  ) else $error("count does not match head/skid occupancy");

  ready_matches_count: assert property (
    @(posedge clk) disable iff (!rst_n)
    in_ready == (count != 2'd2)
  ) else $error("in_ready disagrees with occupancy");

endmodule

// File: rtl/operand_skid_reg.sv
// Registered operand stage behind the operand selector: 2-entry skid buffer
// with valid/ready on both sides and registered zero/negative flags.
module operand_skid_reg
  import operand_skid_reg_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SRC_W = operand_skid_reg_pkg::SRC_W
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  input  logic [SRC_W-1:0] In_Src,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic [SRC_W-1:0] Out_Src,
  output logic             Out_Zero,
  output logic             Out_Neg,
  output logic [1:0]       Count
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] head_data_r;
  logic [WIDTH-1:0] head_data_nxt_s;
  logic [SRC_W-1:0] head_src_r;
  logic [SRC_W-1:0] head_src_nxt_s;
  logic [WIDTH-1:0] skid_data_r;
  logic [WIDTH-1:0] skid_data_nxt_s;
  logic [SRC_W-1:0] skid_src_r;
  logic [SRC_W-1:0] skid_src_nxt_s;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             zero_r;
  logic             neg_r;
  logic [1:0]       count_r;
  logic             push_s;
  logic             pop_s;
  logic             valid_nxt_s;
  logic             flag_zero_s;
  logic             flag_neg_s;

  assign push_s = In_Valid & in_ready_r;
  assign pop_s  = out_valid_r & Out_Ready;

  // Next buffer contents and state; Flush overrides any push/pop.
  always_comb begin
    state_nxt_s     = state_r;
    head_data_nxt_s = head_data_r;
    head_src_nxt_s  = head_src_r;
    skid_data_nxt_s = skid_data_r;
    skid_src_nxt_s  = skid_src_r;
    if (Flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            head_data_nxt_s = In_Data;
            head_src_nxt_s  = In_Src;
            state_nxt_s     = ONE;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_data_nxt_s = In_Data;
            head_src_nxt_s  = In_Src;
            state_nxt_s     = ONE;
          end else if (push_s) begin
            skid_data_nxt_s = In_Data;
            skid_src_nxt_s  = In_Src;
            state_nxt_s     = FULL;
          end else if (pop_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          // In_Ready is low here, so only a pop can move the buffer.
          if (pop_s) begin
            head_data_nxt_s = skid_data_r;
            head_src_nxt_s  = skid_src_r;
            state_nxt_s     = ONE;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  assign valid_nxt_s = (state_nxt_s != EMPTY);

  operand_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .data (head_data_nxt_s),
    .zero (flag_zero_s),
    .neg  (flag_neg_s)
  );

  // State, storage and all handshake/flag outputs registered together.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_r     <= EMPTY;
      head_data_r <= {WIDTH{1'b0}};
      head_src_r  <= {SRC_W{1'b0}};
      skid_data_r <= {WIDTH{1'b0}};
      skid_src_r  <= {SRC_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      count_r     <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      head_data_r <= head_data_nxt_s;
      head_src_r  <= head_src_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_src_r  <= skid_src_nxt_s;
      out_valid_r <= valid_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      zero_r      <= flag_zero_s & valid_nxt_s;
      neg_r       <= flag_neg_s & valid_nxt_s;
      count_r     <= state_count(state_nxt_s);
    end
  end

  assign In_Ready  = in_ready_r;
  assign Out_Valid = out_valid_r;
  assign Out_Data  = head_data_r;
  assign Out_Src   = head_src_r;
  assign Out_Zero  = zero_r;
  assign Out_Neg   = neg_r;
  assign Count     = count_r;

  operand_skid_reg_checker u_checker (
    .clk        (CLK),
    .rst_n      (Reset_n),
    .out_valid  (out_valid_r),
    .skid_valid (state_r == FULL),
    .in_ready   (in_ready_r),
    .count      (count_r)
  );

endmodule
